// File: rtl/unpack.sv
// Serial-to-word packet deserializer: LSB-first bits fill one bank of a
// two-bank RAM while the other bank streams out as words with valid/ready.
module unpack #(
   parameter int SIZE_MEMORY   = 8,
   parameter int SIZE_BIT_PACK = 1976,
   parameter int N_WORDS       = SIZE_BIT_PACK / SIZE_MEMORY,
   parameter int SIZE_ADDR     = $clog2(N_WORDS)
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_data,
   input  logic                   i_valid_input,
   output logic                   o_ready_input,
   output logic [SIZE_MEMORY-1:0] o_data,
   output logic                   o_valid,
   output logic                   o_last,
   input  logic                   i_ready_output
);

   localparam int CNT_W = (SIZE_MEMORY > 1) ? $clog2(SIZE_MEMORY) : 1;
   localparam int DEPTH = 2 ** (SIZE_ADDR + 1);
   localparam logic [CNT_W-1:0]     LAST_BIT  = CNT_W'(SIZE_MEMORY - 1);
   localparam logic [SIZE_ADDR-1:0] LAST_WORD = SIZE_ADDR'(N_WORDS - 1);

   typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_t;

   // Bank select is the address MSB, so each bank spans a power-of-two range.
   logic [SIZE_MEMORY-1:0] ram [DEPTH];

   logic [1:0]             full_q;
   logic                   wr_bank_q;
   logic                   rd_bank_q;
   logic [CNT_W-1:0]       bit_cnt_q;
   logic [SIZE_ADDR-1:0]   waddr_q;
   logic [SIZE_ADDR-1:0]   raddr_q;
   logic [SIZE_MEMORY-1:0] shift_q;
   logic [SIZE_MEMORY-1:0] shift_d;
   state_t                 state_q;
   logic [SIZE_MEMORY-1:0] o_data_q;
   logic                   o_valid_q;
   logic                   o_last_q;

   logic       bit_accept;
   logic       word_done;
   logic       pack_done;
   logic       out_fire;
   logic       rel_done;
   logic [1:0] full_set;
   logic [1:0] full_clr;

   always_comb begin
      bit_accept = i_valid_input && !full_q[wr_bank_q];
      shift_d    = {i_data, shift_q[SIZE_MEMORY-1:1]};
      word_done  = bit_accept && (bit_cnt_q == LAST_BIT);
      pack_done  = word_done && (waddr_q == LAST_WORD);
      out_fire   = o_valid_q && i_ready_output;
      rel_done   = (state_q == STREAM) && out_fire && o_last_q;
      full_set   = pack_done ? (2'b01 << wr_bank_q) : '0;
      full_clr   = rel_done  ? (2'b01 << rd_bank_q) : '0;
   end

   assign o_ready_input = !full_q[wr_bank_q];
   assign o_data        = o_data_q;
   assign o_valid       = o_valid_q;
   assign o_last        = o_last_q;

   always_ff @(posedge i_clk) begin
      if (word_done)
         ram[{wr_bank_q, waddr_q}] <= shift_d;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         shift_q   <= '0;
         bit_cnt_q <= '0;
         waddr_q   <= '0;
         wr_bank_q <= 1'b0;
      end else if (bit_accept) begin
         shift_q <= shift_d;
         if (word_done) begin
            bit_cnt_q <= '0;
            if (pack_done) begin
               waddr_q   <= '0;
               wr_bank_q <= ~wr_bank_q;
            end else begin
               waddr_q <= waddr_q + SIZE_ADDR'(1);
            end
         end else begin
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
         end
      end
   end

   // Writer and reader never share a bank, so set and clear are independent.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         full_q <= '0;
      else
         full_q <= (full_q | full_set) & ~full_clr;
   end

   // The output register doubles as the RAM read register: loading it only
   // on acceptance keeps o_data stable under backpressure at full throughput.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q   <= IDLE;
         rd_bank_q <= 1'b0;
         raddr_q   <= '0;
         o_data_q  <= '0;
         o_valid_q <= 1'b0;
         o_last_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               raddr_q <= '0;
               if (full_q[rd_bank_q])
                  state_q <= FETCH;
            end
            FETCH: begin
               o_data_q  <= ram[{rd_bank_q, {SIZE_ADDR{1'b0}}}];
               o_valid_q <= 1'b1;
               o_last_q  <= (N_WORDS == 1);
               raddr_q   <= SIZE_ADDR'(1);
               state_q   <= STREAM;
            end
            STREAM: begin
               if (out_fire) begin
                  if (o_last_q) begin
                     o_valid_q <= 1'b0;
                     o_last_q  <= 1'b0;
                     rd_bank_q <= ~rd_bank_q;
                     state_q   <= IDLE;
                  end else begin
                     o_data_q <= ram[{rd_bank_q, raddr_q}];
                     o_last_q <= (raddr_q == LAST_WORD);
                     raddr_q  <= raddr_q + SIZE_ADDR'(1);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_unpack.sv
// Bench for unpack: one default-size and one 32-bit-packet instance, with a
// scoreboard of expected words checked on every output handshake.
module tb_unpack;

   localparam int BUDGET = 3000;

   logic clk = 1'b0;
   logic rst, din, vin, rdy_out, sel;
   logic rdy_d, rdy_s, val_d, val_s, last_d, last_s;
   logic [7:0] dat_d, dat_s;
   logic o_ready, o_valid, o_last;
   logic [7:0] o_data;

   always #5 clk = ~clk;

   unpack dut_d (
      .i_clk(clk), .i_reset(rst), .i_data(din), .i_valid_input(vin),
      .o_ready_input(rdy_d), .o_data(dat_d), .o_valid(val_d), .o_last(last_d),
      .i_ready_output(rdy_out)
   );

   unpack #(.SIZE_BIT_PACK(32)) dut_s (
      .i_clk(clk), .i_reset(rst), .i_data(din), .i_valid_input(vin),
      .o_ready_input(rdy_s), .o_data(dat_s), .o_valid(val_s), .o_last(last_s),
      .i_ready_output(rdy_out)
   );

   assign o_ready = sel ? rdy_s  : rdy_d;
   assign o_valid = sel ? val_s  : val_d;
   assign o_last  = sel ? last_s : last_d;
   assign o_data  = sel ? dat_s  : dat_d;

   typedef struct packed {logic [7:0] d; logic l;} exp_t;
   typedef struct {logic [7:0] w; logic l;} vec_t;

   exp_t q[$];
   int errors = 0, checks = 0, pops = 0, ready_drops = 0;
   bit watch_ready = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Output monitor: hold checks while stalled, scoreboard pop on handshake.
   initial begin
      logic stall_prev, prev_l;
      logic [7:0] prev_d;
      exp_t e;
      stall_prev = 1'b0;
      prev_l = 1'b0;
      prev_d = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall_prev = 1'b0;
         end else begin
            if (watch_ready && !o_ready) ready_drops++;
            if (stall_prev) begin
               chk("hold_valid", 32'(o_valid), 1);
               chk("hold_data", 32'(o_data), 32'(prev_d));
               chk("hold_last", 32'(o_last), 32'(prev_l));
            end
            if (o_valid && rdy_out) begin
               if (q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_word: got 0x%0h, expected no output", o_data);
               end else begin
                  e = q.pop_front();
                  chk("data", 32'(o_data), 32'(e.d));
                  chk("last", 32'(o_last), 32'(e.l));
               end
               pops++;
            end
            stall_prev = o_valid && !rdy_out;
            prev_d = o_data;
            prev_l = o_last;
         end
      end
   end

   task automatic do_reset(input logic s, input logic r);
      rst = 1'b1;
      vin = 1'b0;
      din = 1'b0;
      sel = s;
      rdy_out = r;
      repeat (2) @(posedge clk);
      #1;
      q.delete();
      pops = 0;
      rst = 1'b0;
   endtask

   task automatic send_bit(input logic b, input int gap);
      int t = 0;
      if (gap > 0) begin
         vin = 1'b0;
         repeat (gap) begin @(posedge clk); #1; end
      end
      din = b;
      vin = 1'b1;
      forever begin
         @(negedge clk);
         if (o_ready) break;
         t++;
         if (t >= BUDGET) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no o_ready_input, expected bit accepted within %0d cycles", BUDGET);
            vin = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [7:0] w, input logic l, input int maxgap);
      q.push_back('{d: w, l: l});
      for (int i = 0; i < 8; i++)
         send_bit(w[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
   endtask

   task automatic drain(input string name, input int budget, input int exp_pops);
      int t = 0;
      vin = 1'b0;
      while (q.size() != 0 && t < budget) begin @(negedge clk); t++; end
      repeat (2) @(negedge clk);
      #1;
      chk({name, "_queue_empty"}, 32'(q.size()), 0);
      chk({name, "_word_count"}, 32'(pops), 32'(exp_pops));
      chk({name, "_idle_valid"}, 32'(o_valid), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1);
   end

   initial begin
      vec_t gap_tbl[4];
      int seen;
      gap_tbl[0] = '{w: 8'hA5, l: 1'b0};
      gap_tbl[1] = '{w: 8'h3C, l: 1'b0};
      gap_tbl[2] = '{w: 8'hFF, l: 1'b0};
      gap_tbl[3] = '{w: 8'h01, l: 1'b1};

      // Reset state
      do_reset(1'b0, 1'b1);
      chk("rst_valid", 32'(o_valid), 0);
      chk("rst_last", 32'(o_last), 0);
      chk("rst_data", 32'(o_data), 0);
      chk("rst_ready", 32'(o_ready), 1);

      // Single default packet, latency and back-to-back stream
      for (int w = 0; w < 247; w++) send_word(8'(w), w == 246, 0);
      vin = 1'b0;
      @(negedge clk); chk("lat_t0_valid", 32'(o_valid), 0);
      @(negedge clk); chk("lat_t1_valid", 32'(o_valid), 0);
      @(negedge clk); chk("lat_t2_valid", 32'(o_valid), 1);
      repeat (246) @(negedge clk);
      #1;
      chk("stream_consecutive", 32'(pops), 247);
      drain("single", 500, 247);

      // Input gaps, table-driven
      do_reset(1'b1, 1'b1);
      for (int i = 0; i < 4; i++) send_word(gap_tbl[i].w, gap_tbl[i].l, 3);
      drain("gaps", 200, 4);

      // Random backpressure over three packets
      do_reset(1'b1, 1'b1);
      fork
         begin
            for (int p = 0; p < 3; p++)
               for (int i = 0; i < 4; i++) send_word(8'($urandom), i == 3, 1);
            vin = 1'b0;
         end
         begin
            repeat (300) begin @(posedge clk); #1; rdy_out = 1'($urandom_range(0, 1)); end
            rdy_out = 1'b1;
         end
      join
      drain("bp", 500, 12);

      // Ping-pong full with reader blocked
      do_reset(1'b1, 1'b0);
      for (int i = 0; i < 8; i++) send_word(8'(8'h10 + i), (i % 4) == 3, 0);
      @(negedge clk); chk("pp_full_ready", 32'(o_ready), 0);
      seen = 0;
      repeat (5) begin @(negedge clk); if (o_ready) seen++; end
      chk("pp_full_hold", 32'(seen), 0);
      @(posedge clk); #1;
      vin = 1'b0;
      rdy_out = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk); chk($sformatf("pp_wait_%0d", i), 32'(o_ready), 0);
      end
      @(negedge clk); chk("pp_release_ready", 32'(o_ready), 1);
      drain("pp", 200, 8);

      // Reset mid-packet during an output stall
      do_reset(1'b1, 1'b0);
      for (int i = 0; i < 4; i++) send_word(8'(8'h5A + i), i == 3, 0);
      for (int i = 0; i < 13; i++) send_bit(1'(i % 2), 0);
      vin = 1'b0;
      @(negedge clk); chk("pre_reset_valid", 32'(o_valid), 1);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(o_valid), 0);
      chk("mid_rst_last", 32'(o_last), 0);
      chk("mid_rst_data", 32'(o_data), 0);
      chk("mid_rst_ready", 32'(o_ready), 1);
      q.delete();
      @(posedge clk); #1;
      pops = 0;
      rst = 1'b0;
      rdy_out = 1'b1;
      for (int i = 0; i < 4; i++) send_word(8'(8'hC1 + i * 5), i == 3, 0);
      drain("post_reset", 200, 4);

      // Three default packets back to back
      do_reset(1'b0, 1'b1);
      ready_drops = 0;
      watch_ready = 1'b1;
      for (int p = 0; p < 3; p++)
         for (int i = 0; i < 247; i++) send_word(8'(i * 3 + p * 17), i == 246, 0);
      vin = 1'b0;
      watch_ready = 1'b0;
      chk("b2b_ready_drops", 32'(ready_drops), 0);
      drain("b2b", 1000, 741);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
